ram512x1_arbiter: RTL and testbench

- Shares one 512x1 single-port distributed RAM (synchronous write, asynchronous read) between two requesters, A and B.
- Uses round-robin arbitration with a valid/acknowledge handshake per port.
- Contains a clear sequencer that writes every location to a known value after reset and on command.
- Sits between client logic (bitmaps, flag tables) and the RAM primitive; it owns the RAM's WE/A/D pins.

---
 rtl/ram512x1_arbiter.sv | 115 +++++++++++
 tb/tb_ram512x1_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram512x1_arbiter.sv
// Round-robin two-port front end for a 512x1 distributed RAM, with a
// clear sequencer that sweeps every location after reset or on CLR.
//
// state   | meaning
// S_CLEAR | sweep writing CLR_VAL to address cnt, one location per cycle
// S_IDLE  | servicing port A/B requests, at most one grant per cycle
module ram512x1_arbiter #(
  parameter logic CLR_VAL = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLR,
  output logic       BUSY,
  input  logic       A_REQ,
  input  logic       A_WE,
  input  logic [8:0] A_ADDR,
  input  logic       A_D,
  output logic       A_ACK,
  output logic       A_Q,
  input  logic       B_REQ,
  input  logic       B_WE,
  input  logic [8:0] B_ADDR,
  input  logic       B_D,
  output logic       B_ACK,
  output logic       B_Q,
  output logic       RAM_WE,
  output logic [8:0] RAM_A,
  output logic       RAM_D,
  input  logic       RAM_O
);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t     state;
  logic [8:0] cnt;
  logic [8:0] addr_hold;
  logic       last_b;
  logic       a_elig, b_elig;
  logic       grant_a, grant_b;

  // A port still in its ACK cycle is not eligible, so a held request
  // cannot be granted twice.
  always_comb begin
    a_elig  = (state == S_IDLE) && !CLR && A_REQ && !A_ACK;
    b_elig  = (state == S_IDLE) && !CLR && B_REQ && !B_ACK;
    grant_a = a_elig && (!b_elig || last_b);
    grant_b = b_elig && (!a_elig || !last_b);
  end

  always_comb begin
    RAM_WE = 1'b0;
    RAM_A  = addr_hold;
    RAM_D  = 1'b0;
    if (RST) begin
      RAM_A = '0;
      RAM_D = CLR_VAL;
    end else if (state == S_CLEAR) begin
      RAM_WE = 1'b1;
      RAM_A  = cnt;
      RAM_D  = CLR_VAL;
    end else if (grant_a) begin
      RAM_WE = A_WE;
      RAM_A  = A_ADDR;
      RAM_D  = A_D;
    end else if (grant_b) begin
      RAM_WE = B_WE;
      RAM_A  = B_ADDR;
      RAM_D  = B_D;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_CLEAR;
      cnt       <= '0;
      BUSY      <= 1'b1;
      last_b    <= 1'b1;
      A_ACK     <= 1'b0;
      B_ACK     <= 1'b0;
      A_Q       <= 1'b0;
      B_Q       <= 1'b0;
      addr_hold <= '0;
    end else begin
      A_ACK     <= grant_a;
      B_ACK     <= grant_b;
      addr_hold <= RAM_A;
      // RAM_O is sampled on the write edge, so writes return the old value
      if (grant_a) begin
        A_Q    <= RAM_O;
        last_b <= 1'b0;
      end
      if (grant_b) begin
        B_Q    <= RAM_O;
        last_b <= 1'b1;
      end
      case (state)
        S_CLEAR: begin
          cnt <= cnt + 9'd1;
          if (cnt == 9'd511) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (CLR) begin
            state <= S_CLEAR;
            BUSY  <= 1'b1;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_ram512x1_arbiter.sv
// Randomized bench for ram512x1_arbiter: behavioural RAM on the RAM pins and
// an independent reference memory that predicts every Q value.
module tb_ram512x1_arbiter;

  localparam logic CLRV = 1'b0;

  logic       CLK = 1'b0;
  logic       RST, CLR, BUSY;
  logic       A_REQ, A_WE, A_D, A_ACK, A_Q;
  logic [8:0] A_ADDR;
  logic       B_REQ, B_WE, B_D, B_ACK, B_Q;
  logic [8:0] B_ADDR;
  logic       RAM_WE, RAM_D, RAM_O;
  logic [8:0] RAM_A;

  int checks = 0;
  int errors = 0;

  logic       ref_mem [512];
  int         last_port;

  logic       tb_ram [512];
  logic       fill_en = 1'b0;
  logic [8:0] fill_addr = '0;

  ram512x1_arbiter #(.CLR_VAL(CLRV)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .BUSY(BUSY),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_D(A_D), .A_ACK(A_ACK), .A_Q(A_Q),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_D(B_D), .B_ACK(B_ACK), .B_Q(B_Q),
    .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_D(RAM_D), .RAM_O(RAM_O)
  );

  always #5 CLK = ~CLK;

  // Behavioural distributed RAM; fill_en scribbles random garbage first
  always @(posedge CLK) begin
    if (fill_en) begin
      tb_ram[fill_addr] <= 1'($urandom);
      fill_addr <= fill_addr + 9'd1;
    end else if (RAM_WE) begin
      tb_ram[RAM_A] <= RAM_D;
    end
  end
  assign RAM_O = tb_ram[RAM_A];

  task automatic drive_port(input int p, input logic req, input logic we,
                            input logic [8:0] ad, input logic d);
    if (p == 0) begin A_REQ = req; A_WE = we; A_ADDR = ad; A_D = d; end
    else        begin B_REQ = req; B_WE = we; B_ADDR = ad; B_D = d; end
  endtask

  task automatic ref_cleared();
    for (int i = 0; i < 512; i++) ref_mem[i] = CLRV;
    last_port = 1;
  endtask

  // Single access on one port; waits for ACK and checks Q against the model
  task automatic access(input int p, input logic we, input logic [8:0] ad,
                        input logic d, input int max_lat, input string name);
    logic exp_q, q, got;
    int n;
    exp_q = ref_mem[ad];
    drive_port(p, 1'b1, we, ad, d);
    n = 0; got = 1'b0;
    while (!got && n < 1100) begin
      @(negedge CLK); n++;
      got = (p == 0) ? A_ACK : B_ACK;
    end
    checks++;
    if (!got || n > max_lat) begin
      errors++;
      $display("FAIL %s latency: ack=%b after %0d cycles, want ack within %0d", name, got, n, max_lat);
    end
    if (got) begin
      q = (p == 0) ? A_Q : B_Q;
      checks++;
      if (q !== exp_q) begin
        errors++;
        $display("FAIL %s q: got %b want %b (port %0d addr %0d)", name, q, exp_q, p, ad);
      end
      if (we) ref_mem[ad] = d;
      last_port = p;
    end
    drive_port(p, 1'b0, 1'b0, 9'd0, 1'b0);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; CLR = 1'b0;
    drive_port(0, 1'b0, 1'b0, 9'd0, 1'b0);
    drive_port(1, 1'b0, 1'b0, 9'd0, 1'b0);
    fill_en = 1'b1;
    repeat (514) @(negedge CLK);
    fill_en = 1'b0;
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1 || A_ACK !== 1'b0 || B_ACK !== 1'b0 || A_Q !== 1'b0 || B_Q !== 1'b0) begin
      errors++;
      $display("FAIL reset regs: BUSY=%b A_ACK=%b B_ACK=%b A_Q=%b B_Q=%b, want 1 0 0 0 0",
               BUSY, A_ACK, B_ACK, A_Q, B_Q);
    end
    checks++;
    if (RAM_WE !== 1'b0 || RAM_A !== 9'd0 || RAM_D !== CLRV) begin
      errors++;
      $display("FAIL reset ram pins: WE=%b A=%0d D=%b, want 0 0 %b", RAM_WE, RAM_A, RAM_D, CLRV);
    end
  endtask

  task automatic test_sweep();
    RST = 1'b0;
    #1;
    for (int i = 0; i < 512; i++) begin
      checks++;
      if (BUSY !== 1'b1 || RAM_WE !== 1'b1 || RAM_A !== 9'(i) || RAM_D !== CLRV) begin
        errors++;
        $display("FAIL sweep[%0d]: BUSY=%b WE=%b A=%0d D=%b, want 1 1 %0d %b",
                 i, BUSY, RAM_WE, RAM_A, RAM_D, i, CLRV);
      end
      @(negedge CLK);
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL sweep end: BUSY=%b in cycle 513, want 0", BUSY);
    end
    ref_cleared();
    access(0, 1'b0, 9'h1FF, 1'b0, 1, "read_1ff");
  endtask

  task automatic test_rw();
    access(0, 1'b1, 9'h0A5, 1'b1, 1, "a_write_0a5");
    access(1, 1'b0, 9'h0A5, 1'b0, 1, "b_read_0a5");
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      access(int'($urandom_range(0, 1)), 1'($urandom), 9'($urandom_range(160, 175)),
             1'($urandom), 1, "rand_access");
  endtask

  task automatic test_interleave();
    logic       we [2];
    logic [8:0] ad [2];
    logic       dd [2];
    bit         active [2];
    int issued, expect_p, p, n;
    logic exp_q, q;
    for (int i = 0; i < 2; i++) begin
      we[i] = 1'($urandom); ad[i] = 9'($urandom_range(0, 7)); dd[i] = 1'($urandom);
      drive_port(i, 1'b1, we[i], ad[i], dd[i]);
      active[i] = 1'b1;
    end
    issued = 2; expect_p = 1 - last_port; n = 0;
    while ((active[0] || active[1]) && n < 200) begin
      @(negedge CLK); n++;
      checks++;
      if (A_ACK === B_ACK) begin
        errors++;
        $display("FAIL interleave ack: A_ACK=%b B_ACK=%b, want exactly one (cycle %0d)", A_ACK, B_ACK, n);
      end else begin
        p = (B_ACK === 1'b1) ? 1 : 0;
        checks++;
        if (p != expect_p) begin
          errors++;
          $display("FAIL interleave order: acked port %0d, want port %0d", p, expect_p);
        end
        exp_q = ref_mem[ad[p]];
        q = (p == 0) ? A_Q : B_Q;
        checks++;
        if (q !== exp_q) begin
          errors++;
          $display("FAIL interleave q: port %0d addr %0d got %b want %b", p, ad[p], q, exp_q);
        end
        if (we[p]) ref_mem[ad[p]] = dd[p];
        last_port = p; expect_p = 1 - p;
        if (issued < 30) begin
          we[p] = 1'($urandom); ad[p] = 9'($urandom_range(0, 7)); dd[p] = 1'($urandom);
          drive_port(p, 1'b1, we[p], ad[p], dd[p]);
          issued++;
        end else begin
          drive_port(p, 1'b0, 1'b0, 9'd0, 1'b0);
          active[p] = 1'b0;
        end
      end
    end
    checks++;
    if (active[0] || active[1]) begin
      errors++;
      $display("FAIL interleave timeout: active A=%b B=%b after %0d cycles, want both done", active[0], active[1], n);
      drive_port(0, 1'b0, 1'b0, 9'd0, 1'b0);
      drive_port(1, 1'b0, 1'b0, 9'd0, 1'b0);
    end
    @(negedge CLK);
  endtask

  task automatic test_clr();
    logic [8:0] x;
    int n;
    x = 9'h133;
    access(0, 1'b1, x, 1'b1, 1, "clr_prewrite");
    drive_port(0, 1'b1, 1'b0, x, 1'b0);
    @(negedge CLK);
    checks++;
    if (A_ACK !== 1'b1 || A_Q !== 1'b1) begin
      errors++;
      $display("FAIL clr owed ack: A_ACK=%b A_Q=%b, want 1 1", A_ACK, A_Q);
    end
    drive_port(0, 1'b0, 1'b0, 9'd0, 1'b0);
    CLR = 1'b1;
    drive_port(1, 1'b1, 1'b0, x, 1'b0);
    #1;
    checks++;
    if (RAM_WE !== 1'b0 || A_ACK !== 1'b1) begin
      errors++;
      $display("FAIL clr cycle: RAM_WE=%b A_ACK=%b, want 0 1", RAM_WE, A_ACK);
    end
    @(negedge CLK);
    CLR = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || RAM_A !== 9'd0 || RAM_WE !== 1'b1) begin
      errors++;
      $display("FAIL clr start: BUSY=%b A=%0d WE=%b, want 1 0 1", BUSY, RAM_A, RAM_WE);
    end
    n = 0;
    while (BUSY === 1'b1 && n < 600) begin
      checks++;
      if (B_ACK !== 1'b0) begin
        errors++;
        $display("FAIL clr b granted: B_ACK=%b during sweep cycle %0d, want 0", B_ACK, n);
      end
      @(negedge CLK); n++;
    end
    checks++;
    if (n != 512) begin
      errors++;
      $display("FAIL clr busy length: %0d cycles, want 512", n);
    end
    ref_cleared();
    @(negedge CLK);
    checks++;
    if (B_ACK !== 1'b1 || B_Q !== CLRV) begin
      errors++;
      $display("FAIL clr b service: B_ACK=%b B_Q=%b, want 1 %b", B_ACK, B_Q, CLRV);
    end
    drive_port(1, 1'b0, 1'b0, 9'd0, 1'b0);
    last_port = 1;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    int n;
    drive_port(0, 1'b1, 1'b1, 9'd5, 1'b1);
    @(negedge CLK);
    drive_port(0, 1'b1, 1'b0, 9'd5, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (A_ACK !== 1'b1 || A_Q !== 1'b1) begin
      errors++;
      $display("FAIL stream before reset: A_ACK=%b A_Q=%b, want 1 1", A_ACK, A_Q);
    end
    RST = 1'b1;
    drive_port(0, 1'b0, 1'b0, 9'd0, 1'b0);
    #1;
    checks++;
    if (A_ACK !== 1'b0 || A_Q !== 1'b0 || BUSY !== 1'b1 || RAM_WE !== 1'b0) begin
      errors++;
      $display("FAIL mid-access reset: A_ACK=%b A_Q=%b BUSY=%b WE=%b, want 0 0 1 0", A_ACK, A_Q, BUSY, RAM_WE);
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    n = 0;
    while (RAM_A !== 9'd300 && n < 400) begin
      @(negedge CLK); n++;
    end
    checks++;
    if (n != 300) begin
      errors++;
      $display("FAIL sweep reach 300: took %0d cycles, want 300", n);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (BUSY !== 1'b1 || RAM_WE !== 1'b0 || RAM_A !== 9'd0) begin
      errors++;
      $display("FAIL mid-sweep reset: BUSY=%b WE=%b A=%0d, want 1 0 0", BUSY, RAM_WE, RAM_A);
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    for (int i = 0; i < 512; i++) begin
      checks++;
      if (BUSY !== 1'b1 || RAM_WE !== 1'b1 || RAM_A !== 9'(i)) begin
        errors++;
        $display("FAIL resweep[%0d]: BUSY=%b WE=%b A=%0d, want 1 1 %0d", i, BUSY, RAM_WE, RAM_A, i);
      end
      @(negedge CLK);
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL resweep end: BUSY=%b, want 0", BUSY);
    end
    ref_cleared();
    access(1, 1'b0, 9'd5, 1'b0, 1, "read_after_resweep");
  endtask

  task automatic test_sweep_pending();
    logic exp_a;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 512; i++) begin
      if (i == 10) begin
        drive_port(0, 1'b1, 1'b1, 9'd9, 1'b1);
        drive_port(1, 1'b1, 1'b0, 9'd9, 1'b0);
      end
      @(negedge CLK);
      checks++;
      if (A_ACK !== 1'b0 || B_ACK !== 1'b0 || (i < 511 && BUSY !== 1'b1)) begin
        errors++;
        $display("FAIL pending sweep[%0d]: A_ACK=%b B_ACK=%b BUSY=%b, want 0 0 1", i, A_ACK, B_ACK, BUSY);
      end
    end
    ref_cleared();
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL pending busy: BUSY=%b after 512 cycles, want 0", BUSY);
    end
    exp_a = ref_mem[9];
    ref_mem[9] = 1'b1;
    @(negedge CLK);
    checks++;
    if (A_ACK !== 1'b1 || B_ACK !== 1'b0 || A_Q !== exp_a) begin
      errors++;
      $display("FAIL pending first grant: A_ACK=%b B_ACK=%b A_Q=%b, want 1 0 %b", A_ACK, B_ACK, A_Q, exp_a);
    end
    drive_port(0, 1'b0, 1'b0, 9'd0, 1'b0);
    @(negedge CLK);
    checks++;
    if (B_ACK !== 1'b1 || B_Q !== ref_mem[9]) begin
      errors++;
      $display("FAIL pending second grant: B_ACK=%b B_Q=%b, want 1 %b", B_ACK, B_Q, ref_mem[9]);
    end
    drive_port(1, 1'b0, 1'b0, 9'd0, 1'b0);
    last_port = 1;
    @(negedge CLK);
  endtask

  initial begin
    last_port = 1;
    test_reset();
    test_sweep();
    test_rw();
    test_random();
    test_interleave();
    test_clr();
    test_reset_mid();
    test_sweep_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
